fifo_out: RTL and testbench
===========================

FIFO_OUT -- requirements
Module: fifo_out

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 128-bit write, 32-bit read, 4-word capacity.
REQ-002 clk  input  1  single system clock, all state updates on its rising edge.
REQ-003 n_rst  input  1  reset, asynchronous and active-low.
REQ-004 write_en  input  1  loads data_in as one 128-bit block when sampled high on a rising edge.
REQ-005 read_en  input  1  pops one 32-bit word when sampled high on a rising edge.
REQ-006 data_in  input  128  block to store; bits [127:96] are word 0, [95:64] word 1, [63:32] word 2, [31:0] word 3.
REQ-007 fifo_empty  output  1  high when no words are stored.
REQ-008 fifo_full  output  1  high when all 4 words are stored.
REQ-009 data_out  output  32  registered output word, most recently popped word.

Function
REQ-010 Storage SHALL be 4 x 32-bit word registers, a 2-bit read pointer and a 3-bit word count (0..4).
REQ-011 fifo_empty SHALL equal (count == 0) and fifo_full SHALL equal (count == 4), both combinational from registered state.
REQ-012 Write accepted: write_en high while count == 0 -> all 4 words loaded, pointer = 0, count = 4; fifo_full high and fifo_empty low in the cycle after the edge.
REQ-013 Write ignored: write_en high while count != 0 -> no state change, stored data unaffected.
REQ-014 Read accepted: read_en high while count != 0 -> data_out <= word[pointer], pointer + 1, count - 1, effective in the cycle after the edge.
REQ-015 Read order SHALL be most-significant word first: 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD yields AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD.
REQ-016 Read ignored: read_en high while count == 0 -> data_out holds, no underflow, count stays 0.
REQ-017 data_out SHALL hold its last value while read_en is low; read latency is exactly one clock edge.
REQ-018 Simultaneous write_en and read_en SHALL be evaluated against the pre-edge count; if empty, the write is accepted and the read ignored; if non-empty, the read is accepted and the write ignored.
REQ-019 After the 4th accepted read, count = 0, fifo_empty = 1, and a new write is accepted on the next edge.
REQ-020 Back-to-back reads on consecutive edges SHALL each pop one word, with no idle cycle needed.

Reset
REQ-021 n_rst low SHALL immediately clear count, pointer, word storage and data_out to 0, independent of clk.
REQ-022 During and after reset, fifo_empty = 1, fifo_full = 0 and data_out = 32'h0.
REQ-023 Reset asserted mid-drain SHALL discard the remaining words; the first edge after release behaves as empty.

Structure
REQ-024 Package fifo_out_pkg SHALL hold the constants WORD_W = 32, BLOCK_W = 128, NUM_WORDS = 4 and the count width.
REQ-025 The block SHALL be a single module with no sub-modules; the word selection mux is inline.

Verification
REQ-026 Reset, then 1 idle cycle -> fifo_empty = 1, fifo_full = 0, data_out = 0.
REQ-027 Write 128'hAAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD for 1 cycle -> fifo_full = 1, fifo_empty = 0 next cycle.
REQ-028 Four single-cycle read_en pulses separated by idle cycles -> data_out = AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD in turn, holding between pulses; then fifo_empty = 1.
REQ-029 Write 128'h1111...4444 while 2 words of a prior block remain -> ignored; the next two reads return the old words, then empty.
REQ-030 read_en high while empty for 3 cycles -> data_out unchanged, fifo_empty stays 1; then write and read simultaneously while empty -> write accepted, data_out unchanged.
REQ-031 Assert n_rst low asynchronously after 2 reads -> outputs reset at once; fifo_empty = 1 after release.

Source files
------------

// File: rtl/fifo_out_pkg.sv
// fifo_out_pkg: shared widths for the 128-in / 32-out block FIFO.
package fifo_out_pkg;
  localparam int WORD_W    = 32;
  localparam int BLOCK_W   = 128;
  localparam int NUM_WORDS = 4;
  localparam int CNT_W     = 3;
  localparam int PTR_W     = 2;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_WORDS);
endpackage

// File: rtl/fifo_out.sv
// fifo_out: loads one 128-bit block when empty, pops it as four 32-bit words, most-significant first.
module fifo_out
  import fifo_out_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               write_en,
  input  logic               read_en,
  input  logic [BLOCK_W-1:0] data_in,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic [WORD_W-1:0]  data_out
);
  logic [NUM_WORDS-1:0][WORD_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]                 ptr_q, ptr_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [WORD_W-1:0]                dout_q, dout_d;
  logic                             wr_ok, rd_ok;
  assign fifo_empty = cnt_q == '0;
  assign fifo_full  = cnt_q == CNT_FULL;
  assign data_out   = dout_q;
  // both requests judged against the pre-edge count, so at most one is accepted
  assign wr_ok = write_en && fifo_empty;
  assign rd_ok = read_en && !fifo_empty;
  always_comb begin
    mem_d  = mem_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (wr_ok) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_d[i] = data_in[BLOCK_W-1-WORD_W*i -: WORD_W];
      ptr_d = '0;
      cnt_d = CNT_FULL;
    end else if (rd_ok) begin
      dout_d = mem_q[ptr_q];
      ptr_d  = ptr_q + 1'b1;
      cnt_d  = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_q  <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      mem_q  <= mem_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end
endmodule

// File: tb/tb_fifo_out.sv
// tb_fifo_out: scoreboard bench; accepted reads queue their expected word, checked after the edge.
module tb_fifo_out;
  logic         clk;
  logic         n_rst;
  logic         write_en;
  logic         read_en;
  logic [127:0] data_in;
  logic         fifo_empty;
  logic         fifo_full;
  logic [31:0]  data_out;
  int           n_checks;
  int           n_fail;
  logic [31:0]  store[$];
  logic [31:0]  sb[$];
  logic [31:0]  m_dout;
  fifo_out dut (
    .clk(clk), .n_rst(n_rst), .write_en(write_en), .read_en(read_en),
    .data_in(data_in), .fifo_empty(fifo_empty), .fifo_full(fifo_full), .data_out(data_out)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_flags(input string tag);
    check({tag, "_empty"}, 32'(fifo_empty), 32'(store.size() == 0));
    check({tag, "_full"}, 32'(fifo_full), 32'(store.size() == 4));
  endtask
  task automatic step(input logic we, input logic re, input logic [127:0] d);
    bit wr_ok, rd_ok;
    write_en = we;
    read_en  = re;
    data_in  = d;
    wr_ok = we && store.size() == 0;
    rd_ok = re && store.size() != 0;
    if (wr_ok) for (int i = 0; i < 4; i++) store.push_back(d[127-32*i -: 32]);
    if (rd_ok) sb.push_back(store.pop_front());
    @(posedge clk);
    @(negedge clk);
    write_en = 1'b0;
    read_en  = 1'b0;
    if (sb.size() != 0) begin
      m_dout = sb.pop_front();
      check("data_out", data_out, m_dout);
    end else check("data_hold", data_out, m_dout);
    check_flags("step");
  endtask
  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_dout   = '0;
    n_rst    = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    data_in  = '0;
    #12 n_rst = 1'b1;
    @(negedge clk);
    check("rst_data", data_out, 32'h0);
    check_flags("rst");
    step(0, 0, '0);
    step(1, 0, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, '0);
      step(0, 0, '0);
    end
    step(1, 0, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    step(0, 1, '0);
    step(0, 1, '0);
    step(1, 0, 128'h11111111_22222222_33333333_44444444);
    step(1, 1, 128'h55555555_66666666_77777777_88888888);
    step(0, 1, '0);
    step(0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 1, '0);
    step(1, 1, 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE);
    for (int i = 0; i < 4; i++) step(0, 1, '0);
    step(1, 0, 128'h13579BDF_2468ACE0_0F0F0F0F_F0F0F0F0);
    step(0, 1, '0);
    step(0, 1, '0);
    #2 n_rst = 1'b0;
    #1;
    store.delete();
    sb.delete();
    m_dout = '0;
    check("async_rst_data", data_out, 32'h0);
    check_flags("async_rst");
    #9 n_rst = 1'b1;
    @(negedge clk);
    step(0, 1, '0);
    step(1, 0, 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C);
    for (int i = 0; i < 4; i++) step(0, 1, '0);
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
